axis_wait_buffer: RTL and testbench
===================================

// Module: axis_wait_buffer
// PURPOSE
//  AXI-Stream store/wait/replay buffer for the CNN accelerator stream path. Captures one
//  frame (up to DEPTH words, ended by s_tlast) into on-chip RAM, pulses ex_start, holds for
//  a run-time programmable number of cycles, then replays the frame on the master port with
//  m_tlast. This is the parametrised successor of the fixed 8-bit-counter wait datapath.
// PARAMETERS
//  DATA_WIDTH  32  stream word width (bits)
//  DEPTH       16  max words per frame (RAM depth, >=2)
//  CNT_WIDTH   8   width of the wait_cycles input and the wait counter
// PORTS
//  clk          in   1               single clock, rising edge
//  rst          in   1               asynchronous, active-high reset
//  wait_cycles  in   CNT_WIDTH       hold length; sampled on FILL->WAIT transition
//  s_tdata      in   DATA_WIDTH      slave data
//  s_tvalid     in   1               slave valid
//  s_tlast      in   1               slave end-of-frame
//  s_tready     out  1               slave ready
//  m_tdata      out  DATA_WIDTH      master data (registered)
//  m_tvalid     out  1               master valid
//  m_tlast      out  1               master end-of-frame
//  m_tready     in   1               master ready
//  ex_start     out  1               1-cycle pulse on entry to WAIT
//  busy         out  1               high whenever state != IDLE
//  frame_len    out  $clog2(DEPTH+1) word count of the captured frame
// BEHAVIOUR
//  Reset: state=IDLE; s_tready=0, m_tvalid=0, m_tlast=0, m_tdata=0, ex_start=0, busy=0,
//   frame_len=0; wait counter and RAM address cleared. RAM contents are not reset.
//  States: IDLE -> FILL -> WAIT -> DRAIN -> IDLE.
//  IDLE:  s_tready=0. Next cycle unconditionally FILL (s_tready=1 from cycle after reset).
//  FILL:  s_tready=1. Each s_tvalid&s_tready writes RAM[wr_adr], wr_adr++, frame_len++.
//   Exit to WAIT on the beat with s_tlast=1, or on the DEPTH-th beat (forced frame end;
//   s_tready drops in the same cycle as the DEPTH-th write is accepted, so no beat is lost).
//  WAIT:  s_tready=0. ex_start=1 for the first WAIT cycle only. Counter loads wait_cycles,
//   decrements each cycle; exit to DRAIN when counter==0. wait_cycles=0 -> exactly 1 WAIT
//   cycle; wait_cycles=N -> N+1 WAIT cycles. Counter width is CNT_WIDTH; no wrap.
//  DRAIN: RAM read latency 1. First m_tvalid appears 2 cycles after entering DRAIN.
//   Words emitted in write order; m_tlast=1 on word frame_len-1 only.
//   m_tdata/m_tvalid/m_tlast hold stable while m_tvalid&!m_tready (AXIS rule).
//   Throughput 1 word/cycle with m_tready held high. After last handshake -> IDLE,
//   frame_len cleared, m_tvalid=0 in the following cycle.
//  Boundaries: single-word frame (s_tlast on first beat) replays 1 word with m_tlast=1;
//   s_tvalid while not in FILL is ignored (s_tready=0); wait_cycles changes after sampling
//   have no effect; rst asserted in any state aborts immediately to reset values and the
//   partial frame is discarded.
// CONFIGURATION
//  AXIS_WAIT_EXT_DONE_EN defined: adds input ex_done (1 bit) and output timeout (1 bit).
//   In WAIT, ex_done=1 exits to DRAIN next cycle (counter acts as timeout); if the counter
//   reaches 0 first, timeout is set (sticky until next FILL entry, reset 0).
//   ex_done outside WAIT is ignored. Simultaneous ex_done and counter==0: timeout stays 0.
//  Not defined: ports absent; WAIT ends only on counter expiry, as described above.
// TESTING
//  1. 5-word frame 0x11..0x15, s_tlast on 5th, wait_cycles=3, m_tready=1 -> ex_start pulse
//     once, 4 WAIT cycles, 0x11..0x15 out back-to-back, m_tlast on 0x15, frame_len=5.
//  2. 20 beats without s_tlast, DEPTH=16 -> s_tready low after 16th beat, 16 words replayed,
//     m_tlast on word 16, beats 17..20 not accepted.
//  3. Drain with m_tready toggling 1,0,0,1 -> no word dropped or duplicated; data stable
//     while stalled.
//  4. wait_cycles=0 and 1-word frame 0xAB -> single WAIT cycle; 0xAB out with m_tlast=1.
//  5. rst pulsed mid-DRAIN after 2 of 6 words -> all outputs to reset values immediately;
//     next frame replays correctly from address 0.
//  6. (AXIS_WAIT_EXT_DONE_EN) wait_cycles=50, ex_done at WAIT cycle 4 -> DRAIN next cycle,
//     timeout=0; repeat with no ex_done -> timeout=1 after 51 WAIT cycles.

Source files
------------

// File: rtl/axis_wait_buffer.sv
`default_nettype none
// ============================================================================
// Module   : axis_wait_buffer
// Desc     : AXI-Stream store/wait/replay buffer; optional AXIS_WAIT_EXT_DONE_EN
//            adds ex_done / timeout for externally terminated waits.
// Revision : 1.0
// ============================================================================
module axis_wait_buffer #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [CNT_WIDTH-1:0]         wait_cycles,
    input  logic [DATA_WIDTH-1:0]        s_tdata,
    input  logic                         s_tvalid,
    input  logic                         s_tlast,
    output logic                         s_tready,
    output logic [DATA_WIDTH-1:0]        m_tdata,
    output logic                         m_tvalid,
    output logic                         m_tlast,
    input  logic                         m_tready,
    output logic                         ex_start,
    output logic                         busy,
`ifdef AXIS_WAIT_EXT_DONE_EN
    input  logic                         ex_done,
    output logic                         timeout,
`endif
    output logic [$clog2(DEPTH+1)-1:0]   frame_len
);

    localparam int c_AW = $clog2(DEPTH);
    localparam int c_LW = $clog2(DEPTH + 1);
    localparam logic [c_LW-1:0]      c_LEN_ONE  = c_LW'(1);
    localparam logic [c_LW-1:0]      c_LEN_LAST = c_LW'(DEPTH - 1);
    localparam logic [CNT_WIDTH-1:0] c_CNT_ONE  = CNT_WIDTH'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FILL  = 2'd1,
        S_WAIT  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t                 state_q;
    logic                   s_tready_q;
    logic                   ex_start_q;
    logic                   busy_q;
    logic [c_LW-1:0]        frame_len_q;
    logic [c_LW-1:0]        rd_adr_q;
    logic [CNT_WIDTH-1:0]   cnt_q;
    logic                   r1_valid_q;
    logic                   r1_last_q;
    logic [DATA_WIDTH-1:0]  rd_data_q;
    logic [DATA_WIDTH-1:0]  m_tdata_q;
    logic                   m_tvalid_q;
    logic                   m_tlast_q;
`ifdef AXIS_WAIT_EXT_DONE_EN
    logic                   timeout_q;
`endif

    logic [DATA_WIDTH-1:0]  mem_q [DEPTH];

    logic w_wr_en;
    logic w_adv;
    logic w_issue;
    logic w_issue_last;
    logic w_rd_en;

    assign w_wr_en      = (state_q == S_FILL) && s_tvalid && s_tready_q;
    // Read stage and output stage advance together; both freeze on a stalled output.
    assign w_adv        = !m_tvalid_q || m_tready;
    assign w_issue      = (state_q == S_DRAIN) && (rd_adr_q < frame_len_q);
    assign w_issue_last = (rd_adr_q + c_LEN_ONE) == frame_len_q;
    assign w_rd_en      = w_adv && w_issue;

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            mem_q[frame_len_q[c_AW-1:0]] <= s_tdata;
        end
        if (w_rd_en) begin
            rd_data_q <= mem_q[rd_adr_q[c_AW-1:0]];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            s_tready_q  <= 1'b0;
            ex_start_q  <= 1'b0;
            busy_q      <= 1'b0;
            frame_len_q <= '0;
            rd_adr_q    <= '0;
            cnt_q       <= '0;
            r1_valid_q  <= 1'b0;
            r1_last_q   <= 1'b0;
            m_tdata_q   <= '0;
            m_tvalid_q  <= 1'b0;
            m_tlast_q   <= 1'b0;
`ifdef AXIS_WAIT_EXT_DONE_EN
            timeout_q   <= 1'b0;
`endif
        end else begin
            ex_start_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    state_q     <= S_FILL;
                    s_tready_q  <= 1'b1;
                    busy_q      <= 1'b1;
                    frame_len_q <= '0;
                    rd_adr_q    <= '0;
`ifdef AXIS_WAIT_EXT_DONE_EN
                    timeout_q   <= 1'b0;
`endif
                end
                S_FILL: begin
                    if (w_wr_en) begin
                        frame_len_q <= frame_len_q + c_LEN_ONE;
                        if (s_tlast || (frame_len_q == c_LEN_LAST)) begin
                            state_q    <= S_WAIT;
                            s_tready_q <= 1'b0;
                            ex_start_q <= 1'b1;
                            cnt_q      <= wait_cycles;
                        end
                    end
                end
                S_WAIT: begin
`ifdef AXIS_WAIT_EXT_DONE_EN
                    // ex_done wins a tie with expiry, so timeout stays clear.
                    if (ex_done) begin
                        state_q <= S_DRAIN;
                    end else if (cnt_q == '0) begin
                        state_q   <= S_DRAIN;
                        timeout_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - c_CNT_ONE;
                    end
`else
                    if (cnt_q == '0) begin
                        state_q <= S_DRAIN;
                    end else begin
                        cnt_q <= cnt_q - c_CNT_ONE;
                    end
`endif
                end
                S_DRAIN: begin
                    if (w_adv) begin
                        r1_valid_q <= w_issue;
                        r1_last_q  <= w_issue_last;
                        if (w_issue) begin
                            rd_adr_q <= rd_adr_q + c_LEN_ONE;
                        end
                        m_tvalid_q <= r1_valid_q;
                        if (r1_valid_q) begin
                            m_tdata_q <= rd_data_q;
                            m_tlast_q <= r1_last_q;
                        end
                    end
                    if (m_tvalid_q && m_tready && m_tlast_q) begin
                        state_q     <= S_IDLE;
                        busy_q      <= 1'b0;
                        frame_len_q <= '0;
                        rd_adr_q    <= '0;
                        r1_valid_q  <= 1'b0;
                        m_tvalid_q  <= 1'b0;
                        m_tlast_q   <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign s_tready  = s_tready_q;
    assign ex_start  = ex_start_q;
    assign busy      = busy_q;
    assign frame_len = frame_len_q;
    assign m_tdata   = m_tdata_q;
    assign m_tvalid  = m_tvalid_q;
    assign m_tlast   = m_tlast_q;
`ifdef AXIS_WAIT_EXT_DONE_EN
    assign timeout   = timeout_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_axis_wait_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_axis_wait_buffer
// Desc     : Directed scoreboard bench for axis_wait_buffer.
// Revision : 1.0
// ============================================================================
module tb_axis_wait_buffer;

    localparam int DW    = 32;
    localparam int DEPTH = 16;
    localparam int CW    = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [CW-1:0] wait_cycles = '0;
    logic [DW-1:0] s_tdata  = '0;
    logic          s_tvalid = 1'b0;
    logic          s_tlast  = 1'b0;
    logic          s_tready;
    logic [DW-1:0] m_tdata;
    logic          m_tvalid;
    logic          m_tlast;
    logic          m_tready = 1'b1;
    logic          ex_start;
    logic          busy;
    logic [4:0]    frame_len;
`ifdef AXIS_WAIT_EXT_DONE_EN
    logic          ex_done = 1'b0;
    logic          timeout;
`endif

    axis_wait_buffer #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .wait_cycles (wait_cycles),
        .s_tdata     (s_tdata),
        .s_tvalid    (s_tvalid),
        .s_tlast     (s_tlast),
        .s_tready    (s_tready),
        .m_tdata     (m_tdata),
        .m_tvalid    (m_tvalid),
        .m_tlast     (m_tlast),
        .m_tready    (m_tready),
        .ex_start    (ex_start),
        .busy        (busy),
`ifdef AXIS_WAIT_EXT_DONE_EN
        .ex_done     (ex_done),
        .timeout     (timeout),
`endif
        .frame_len   (frame_len)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int n_exs    = 0;
    int n_pops   = 0;
    logic [DW:0] exp_q [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: the head of the queue must be on the bus whenever m_tvalid is high.
    always @(negedge clk) begin
        if (!rst) begin
            if (ex_start) n_exs++;
            if (m_tvalid) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL m_word: unexpected word 0x%0h last=%0d", m_tdata, m_tlast);
                end else begin
                    check("m_word", 64'({m_tlast, m_tdata}), 64'(exp_q[0]));
                    if (m_tready) begin
                        void'(exp_q.pop_front());
                        n_pops++;
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [DW-1:0] first, input int n, input bit with_last);
        bit            acc;
        bit            l;
        bit            ended;
        int            fb;
        logic [DW-1:0] d;
        fb    = 0;
        ended = 1'b0;
        for (int i = 0; i < n; i++) begin
            d        = first + DW'(i);
            l        = with_last && (i == n - 1);
            s_tvalid = 1'b1;
            s_tdata  = d;
            s_tlast  = l;
            acc      = 1'b0;
            for (int c = 0; c < (ended ? 1 : 20) && !acc; c++) begin
                @(negedge clk);
                acc = s_tready;
                tick();
            end
            s_tvalid = 1'b0;
            s_tlast  = 1'b0;
            check("beat_accept", 64'(acc), 64'(!ended));
            if (acc && !ended) begin
                exp_q.push_back({l || (fb == DEPTH - 1), d});
                fb++;
                if (l || fb == DEPTH) ended = 1'b1;
            end
        end
    endtask

    task automatic measure(input int n, input int k_exp);
        int k;
        k = 0;
        check("ex_start", 64'(ex_start), 64'd1);
        check("frame_len", 64'(frame_len), 64'(n));
        while (!m_tvalid && k < 200) begin
            tick();
            k++;
        end
        check("wait_latency", 64'(k), 64'(k_exp));
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (busy && k < 500) begin
            tick();
            k++;
        end
        check("idle_busy", 64'(busy), 64'd0);
        check("idle_queue_empty", 64'(exp_q.size()), 64'd0);
        check("idle_frame_len", 64'(frame_len), 64'd0);
        check("idle_m_tvalid", 64'(m_tvalid), 64'd0);
    endtask

    task automatic check_reset_values();
        check("rst_s_tready", 64'(s_tready), 64'd0);
        check("rst_m_tvalid", 64'(m_tvalid), 64'd0);
        check("rst_m_tlast", 64'(m_tlast), 64'd0);
        check("rst_m_tdata", 64'(m_tdata), 64'd0);
        check("rst_ex_start", 64'(ex_start), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_frame_len", 64'(frame_len), 64'd0);
`ifdef AXIS_WAIT_EXT_DONE_EN
        check("rst_timeout", 64'(timeout), 64'd0);
`endif
    endtask

    initial begin
        int       e0;
        int       p0;
        int       k;
        logic [3:0] pat;

        repeat (2) @(posedge clk);
        #1;
        check_reset_values();
        rst = 1'b0;
        @(negedge clk);
        check("idle_s_tready", 64'(s_tready), 64'd0);
        tick();
        check("fill_s_tready", 64'(s_tready), 64'd1);
        check("fill_busy", 64'(busy), 64'd1);

        // 5-word frame, 4 WAIT cycles, back-to-back replay
        wait_cycles = 8'd3;
        e0 = n_exs;
        send_frame(32'h11, 5, 1'b1);
        measure(5, 6);
        wait_idle();
        check("ex_start_count", 64'(n_exs - e0), 64'd1);

        // Overlong frame forced to end at DEPTH words
        wait_cycles = 8'd10;
        send_frame(32'hA000_0000, 20, 1'b0);
        wait_idle();

        // Back-pressure during replay
        wait_cycles = 8'd2;
        pat = 4'b1001;
        send_frame(32'h300, 6, 1'b1);
        for (int i = 0; i < 200 && busy; i++) begin
            m_tready = pat[i % 4];
            tick();
        end
        m_tready = 1'b1;
        wait_idle();

        // Single-word frame with zero wait
        wait_cycles = 8'd0;
        send_frame(32'hAB, 1, 1'b1);
        measure(1, 3);
        wait_idle();

        // Reset in the middle of a replay
        wait_cycles = 8'd1;
        send_frame(32'h500, 6, 1'b1);
        p0 = n_pops;
        k  = 0;
        while (n_pops < p0 + 2 && k < 100) begin
            tick();
            k++;
        end
        check("pops_before_rst", 64'(n_pops - p0), 64'd2);
        exp_q.delete();
        rst = 1'b1;
        #1;
        check_reset_values();
        tick();
        rst = 1'b0;
        wait_cycles = 8'd2;
        send_frame(32'h600, 4, 1'b1);
        measure(4, 5);
        wait_idle();

`ifdef AXIS_WAIT_EXT_DONE_EN
        // External completion ends the wait early
        wait_cycles = 8'd50;
        send_frame(32'h700, 3, 1'b1);
        check("ext_ex_start", 64'(ex_start), 64'd1);
        repeat (3) tick();
        ex_done = 1'b1;
        tick();
        ex_done = 1'b0;
        k = 0;
        while (!m_tvalid && k < 200) begin
            tick();
            k++;
        end
        check("ext_done_latency", 64'(k), 64'd2);
        wait_idle();
        check("ext_timeout_clear", 64'(timeout), 64'd0);

        // No completion: full wait and sticky timeout
        send_frame(32'h800, 2, 1'b1);
        measure(2, 53);
        wait_idle();
        check("ext_timeout_set", 64'(timeout), 64'd1);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", n_errors);
        $fatal(1);
    end

endmodule
`default_nettype wire
